// File: rtl/inert_spi_resp_pkg.sv
// Shared constants for the inertial-sensor SPI responder.
// Register map, CTRL bit positions and frame FSM states.
package inert_spi_resp_pkg;

  localparam logic [6:0] A_CTRL  = 7'h0D;
  localparam logic [6:0] A_WHO   = 7'h0F;
  localparam logic [6:0] A_CFG0  = 7'h10;
  localparam logic [6:0] A_CFG1  = 7'h11;
  localparam logic [6:0] A_YAW_L = 7'h26;
  localparam logic [6:0] A_YAW_H = 7'h27;

  localparam int CTRL_INT_EN = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA
  } state_e;

endpackage

// File: rtl/inert_spi_resp_sync_edge.sv
// Two-flop synchronizer with a third flop for edge detection.
// Level and edges are taken from the 2nd/3rd flops.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sh_q;

  always_ff @(posedge clk) begin
    if (rst) sh_q <= {3{RST_VAL}};
    else     sh_q <= {sh_q[1:0], d_i};
  end

  assign q_o    = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/inert_spi_resp.sv
// SPI slave model of an inertial sensor: register file,
// periodic data-ready interrupt and coherent yaw sample.
module inert_spi_resp
  import inert_spi_resp_pkg::*;
#(
  parameter int         INT_PERIOD   = 2048,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h6A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic [15:0] yaw_rate,
  output logic        wr_strb
);

  localparam logic [15:0] TMR_LAST = 16'(INT_PERIOD - 1);

  logic ss_lvl, ss_rise, ss_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused;

  sync_edge #(.RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst(rst), .d_i(SS_n),
    .q_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_sck (
    .clk(clk), .rst(rst), .d_i(SCLK),
    .q_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d_i(MOSI),
    .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign unused = ^{ss_lvl, sck_lvl, mosi_rise, mosi_fall};

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [15:0] cmd_q;
  logic [7:0]  sh_q;
  logic        lock_q;
  logic [7:0]  ctrl_q, cfg0_q, cfg1_q;
  logic [15:0] hold_q, pend_val_q, tmr_q;
  logic        pend_q, int_q, strb_q;

  logic [15:0] cmd_nx;
  logic [7:0]  rd_val;
  logic        wrap, commit, blocked, rd_yaw;

  assign cmd_nx  = {cmd_q[14:0], mosi_s};
  assign wrap    = ctrl_q[CTRL_INT_EN] && (tmr_q == TMR_LAST);
  assign commit  = ss_rise && (state_q == S_DATA) && (cnt_q == 5'd16);
  assign blocked = (state_q == S_DATA) && lock_q && !ss_rise;
  assign rd_yaw  = (cmd_nx[6:0] == A_YAW_L) || (cmd_nx[6:0] == A_YAW_H);

  // Address is the low 7 bits of cmd_nx on the 8th rise.
  always_comb begin
    rd_val = 8'h00;
    case (cmd_nx[6:0])
      A_WHO:   rd_val = WHO_AM_I_VAL;
      A_CTRL:  rd_val = ctrl_q;
      A_CFG0:  rd_val = cfg0_q;
      A_CFG1:  rd_val = cfg1_q;
      A_YAW_L: rd_val = hold_q[7:0];
      A_YAW_H: rd_val = hold_q[15:8];
      default: rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      sh_q       <= '0;
      lock_q     <= 1'b0;
      ctrl_q     <= '0;
      cfg0_q     <= '0;
      cfg1_q     <= '0;
      hold_q     <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      tmr_q      <= '0;
      int_q      <= 1'b0;
      strb_q     <= 1'b0;
    end else begin
      strb_q <= 1'b0;

      if (!ctrl_q[CTRL_INT_EN] || wrap) tmr_q <= '0;
      else                              tmr_q <= tmr_q + 16'd1;

      if (wrap) begin
        int_q <= 1'b1;
        if (blocked) begin
          pend_q     <= 1'b1;
          pend_val_q <= yaw_rate;
        end else begin
          pend_q <= 1'b0;
          hold_q <= yaw_rate;
        end
      end else if (pend_q && state_q == S_IDLE) begin
        pend_q <= 1'b0;
        hold_q <= pend_val_q;
      end

      if (ss_fall) begin
        state_q <= S_CMD;
        cnt_q   <= '0;
        lock_q  <= 1'b0;
      end else if (ss_rise) begin
        state_q <= S_IDLE;
        lock_q  <= 1'b0;
        if (commit && cmd_q[15]) begin
          if (cmd_q[14:8] == A_YAW_H && !wrap) int_q <= 1'b0;
        end else if (commit) begin
          strb_q <= 1'b1;
          case (cmd_q[14:8])
            A_CTRL: begin
              ctrl_q <= cmd_q[7:0];
              if (!cmd_q[8'(CTRL_INT_EN)]) begin
                tmr_q <= '0;
                int_q <= 1'b0;
              end
            end
            A_CFG0:  cfg0_q <= cmd_q[7:0];
            A_CFG1:  cfg1_q <= cmd_q[7:0];
            default: ;
          endcase
        end
      end else if (state_q != S_IDLE) begin
        if (sck_rise) begin
          cmd_q <= cmd_nx;
          if (cnt_q != 5'd31) cnt_q <= cnt_q + 5'd1;
          if (state_q == S_CMD && cnt_q == 5'd7) begin
            state_q <= S_DATA;
            sh_q    <= cmd_nx[7] ? rd_val : 8'h00;
            lock_q  <= cmd_nx[7] && rd_yaw;
          end
        end else if (sck_fall && state_q == S_DATA && cnt_q >= 5'd9) begin
          sh_q <= {sh_q[6:0], 1'b0};
        end
      end
    end
  end

  assign MISO    = (state_q == S_DATA) ? sh_q[7] : 1'b0;
  assign INT     = int_q;
  assign wr_strb = strb_q;

endmodule

// File: tb/tb_inert_spi_resp.sv
// Directed plus randomized bench for inert_spi_resp with a
// register-map reference model kept at transaction level.
module tb_inert_spi_resp;

  localparam int P = 1024;
  localparam int H = 5;

  logic        clk = 1'b0;
  logic        rst, SS_n, SCLK, MOSI;
  logic        MISO, INT, wr_strb;
  logic [15:0] yaw_rate;

  int nchk = 0;
  int nfail = 0;
  int nstrb = 0;
  int cyc = 0;

  logic [7:0]  m_ctrl, m_cfg0, m_cfg1;
  logic [15:0] m_hold;

  inert_spi_resp #(.INT_PERIOD(P), .WHO_AM_I_VAL(8'h6A)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .INT(INT), .yaw_rate(yaw_rate), .wr_strb(wr_strb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_strb === 1'b1) nstrb <= nstrb + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] m_read(input logic [6:0] a);
    case (a)
      7'h0F:   return 8'h6A;
      7'h0D:   return m_ctrl;
      7'h10:   return m_cfg0;
      7'h11:   return m_cfg1;
      7'h26:   return m_hold[7:0];
      7'h27:   return m_hold[15:8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_write(input logic [6:0] a, input logic [7:0] d);
    if (a == 7'h0D) m_ctrl = d;
    if (a == 7'h10) m_cfg0 = d;
    if (a == 7'h11) m_cfg1 = d;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi(input logic [15:0] f, input int nb,
                     input bit raise, output logic [7:0] rd);
    rd = '0;
    SS_n = 1'b0;
    tick(8);
    for (int i = 0; i < nb; i++) begin
      SCLK = 1'b0;
      MOSI = f[15-i];
      tick(H);
      if (i >= 8 && i < 16) rd[15-i] = MISO;
      SCLK = 1'b1;
      tick(H);
    end
    if (raise) begin
      tick(H);
      SS_n = 1'b1;
      tick(8);
    end
  endtask

  task automatic spi_rd(input string tag, input logic [6:0] a,
                        input logic [7:0] exp);
    logic [7:0] d;
    int s;
    s = nstrb;
    spi({1'b1, a, 8'h00}, 16, 1'b1, d);
    chk(tag, {8'h00, d}, {8'h00, exp});
    chk({tag, "_strb"}, 16'(nstrb - s), 16'd0);
  endtask

  task automatic spi_wr(input logic [6:0] a, input logic [7:0] v);
    logic [7:0] d;
    int s;
    s = nstrb;
    spi({1'b0, a, v}, 16, 1'b1, d);
    m_write(a, v);
    chk("wr_strb", 16'(nstrb - s), 16'd1);
  endtask

  task automatic wait_int(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      if (INT === 1'b1) begin
        t = cyc;
        break;
      end
      tick(1);
    end
    chk("int_rise", {15'd0, INT}, 16'd1);
  endtask

  initial begin
    logic [7:0] d, v;
    logic [6:0] a;
    int tw, s;
    logic [6:0] atab [6];

    atab = '{7'h0D, 7'h0F, 7'h10, 7'h11, 7'h26, 7'h27};
    m_ctrl = '0; m_cfg0 = '0; m_cfg1 = '0; m_hold = '0;
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    yaw_rate = 16'h0000;
    tick(3);
    chk("rst_miso", {15'd0, MISO}, 16'd0);
    chk("rst_int", {15'd0, INT}, 16'd0);
    chk("rst_strb", {15'd0, wr_strb}, 16'd0);
    rst = 1'b0;
    tick(2);

    spi_rd("who", 7'h0F, 8'h6A);
    chk("who_int", {15'd0, INT}, 16'd0);

    spi_wr(7'h10, 8'hC3);
    spi_rd("cfg0", 7'h10, m_read(7'h10));
    spi_rd("unmapped", 7'h55, 8'h00);

    s = nstrb;
    spi({1'b0, 7'h0D, 8'h02}, 12, 1'b1, d);
    chk("abort_strb", 16'(nstrb - s), 16'd0);
    spi_rd("abort_ctrl", 7'h0D, m_read(7'h0D));
    chk("abort_int", {15'd0, INT}, 16'd0);

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 6) == 6) a = 7'($urandom);
      else a = atab[$urandom_range(0, 5)];
      v = 8'($urandom);
      if (a == 7'h0D) v[1] = 1'b0;
      if ($urandom_range(0, 1) == 1) spi_wr(a, v);
      else spi_rd("rand_rd", a, m_read(a));
    end
    spi_rd("rand_ctrl", 7'h0D, m_read(7'h0D));
    spi_rd("rand_cfg0", 7'h10, m_read(7'h10));
    spi_rd("rand_cfg1", 7'h11, m_read(7'h11));

    yaw_rate = 16'h1234;
    spi_wr(7'h0D, 8'h02);
    chk("en_int0", {15'd0, INT}, 16'd0);
    wait_int(P + 50, tw);
    m_hold = 16'h1234;
    spi_rd("yaw_l", 7'h26, m_read(7'h26));
    chk("int_hold", {15'd0, INT}, 16'd1);
    spi_rd("yaw_h", 7'h27, m_read(7'h27));
    chk("int_clr", {15'd0, INT}, 16'd0);

    while (cyc < tw + P - 130) tick(1);
    yaw_rate = 16'hBEEF;
    spi_rd("coh_old", 7'h27, m_read(7'h27));
    m_hold = 16'hBEEF;
    chk("coh_int", {15'd0, INT}, 16'd0);
    spi_rd("coh_new_h", 7'h27, m_read(7'h27));
    spi_rd("coh_new_l", 7'h26, m_read(7'h26));

    wait_int(P + 50, tw);
    spi_wr(7'h0D, 8'h00);
    chk("dis_int", {15'd0, INT}, 16'd0);
    tick(P + 20);
    chk("dis_stay", {15'd0, INT}, 16'd0);
    spi_rd("dis_hold", 7'h27, m_read(7'h27));

    spi_wr(7'h0D, 8'h02);
    spi_wr(7'h11, 8'h5A);
    wait_int(P + 50, tw);
    spi({1'b1, 7'h27, 8'h00}, 12, 1'b0, d);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_miso", {15'd0, MISO}, 16'd0);
    chk("mid_rst_int", {15'd0, INT}, 16'd0);
    rst = 1'b0;
    SS_n = 1'b1;
    SCLK = 1'b1;
    m_ctrl = '0; m_cfg0 = '0; m_cfg1 = '0; m_hold = '0;
    tick(10);
    spi_rd("post_ctrl", 7'h0D, m_read(7'h0D));
    spi_rd("post_cfg1", 7'h11, m_read(7'h11));
    spi_rd("post_hold", 7'h27, m_read(7'h27));
    spi_rd("post_who", 7'h0F, 8'h6A);
    spi_wr(7'h10, 8'hA5);
    spi_rd("post_cfg0", 7'h10, m_read(7'h10));
    chk("post_int", {15'd0, INT}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/inert_spi_resp.md
INERT_SPI_RESP -- requirements
Module: inert_spi_resp

Interface
REQ-001 Parameter INT_PERIOD, default 2048, clk cycles between data-ready INT assertions.
REQ-002 Parameter WHO_AM_I_VAL, default 8'h6A, fixed value of register 0x0F.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 SS_n  input  1  SPI select from the inertial interface, active-low, asynchronous to clk.
REQ-006 SCLK  input  1  SPI clock, idles high, asynchronous to clk.
REQ-007 MOSI  input  1  serial command/data from the interface, MSB first.
REQ-008 MISO  output  1  serial read data to the interface, MSB first.
REQ-009 INT  output  1  data-ready interrupt, active-high, level.
REQ-010 yaw_rate  input  16  sensor sample from the bench, snapshotted on INT rise.
REQ-011 wr_strb  output  1  one-cycle pulse on each completed register write.

Function
REQ-012 SS_n, SCLK and MOSI shall each pass through a 2-flop synchronizer; edges come from the 2nd and 3rd flop; SCLK high and low phases of at least 4 clk are required.
REQ-013 Frame: 16 bits; bit15 R/W (1=read), bits14:8 address, bits7:0 write data (write) or don't-care (read).
REQ-014 MOSI is sampled on each synchronized SCLK rise and shifted into a 16-bit command register; a 5-bit rise counter tracks the bit position.
REQ-015 FSM states IDLE, CMD, DATA; IDLE->CMD on SS_n fall; CMD->DATA after the 8th rise; DATA->IDLE on SS_n rise.
REQ-016 On the 8th rise of a read, the 8-bit value of the addressed register is loaded into a read shifter.
REQ-017 MISO = 0 in IDLE and CMD; in DATA, MISO = read-shifter bit 7; the shifter shifts left (fill 0) on each SCLK fall after the 9th fall, so the master sees data bits 7..0 on rises 9..16.
REQ-018 Register map: 0x0F WHO_AM_I (RO); 0x0D CTRL, RW, bit1 = INT enable; 0x10 and 0x11 CFG, RW, 8-bit; 0x26 yaw_L (RO); 0x27 yaw_H (RO); all others read 8'h00 and ignore writes.
REQ-019 A write commits, and wr_strb pulses, only on SS_n rise with exactly 16 rises counted; writes to RO or unmapped addresses still pulse wr_strb without altering state.
REQ-020 SS_n rise with fewer or more than 16 rises aborts: no write, no INT clear, FSM to IDLE.
REQ-021 SS_n fall while not in IDLE restarts the frame: counter cleared, FSM to CMD.
REQ-022 INT timer: 16-bit counter runs while CTRL[1]=1, wraps at INT_PERIOD-1; at each wrap INT is set and yaw_rate is captured into the yaw_L/yaw_H holding register.
REQ-023 A completed read of 0x27 clears INT at SS_n rise; if a wrap coincides with that clear, the set wins and the new sample is captured.
REQ-024 Writing CTRL[1]=0 clears the timer and INT on the same commit cycle; the held sample is retained.
REQ-025 The holding register is not updated while a read of 0x26 or 0x27 is in progress (FSM in DATA), so L/H reads are coherent; a capture blocked by this is deferred to the first cycle in IDLE.

Reset
REQ-026 rst shall force FSM IDLE, counters 0, MISO 0, INT 0, wr_strb 0, CTRL 8'h00, CFG 8'h00, holding register 16'h0000; rst mid-frame discards the frame.

Structure
REQ-027 A shared package holds the register address constants, the CTRL INT-enable bit index and the FSM state enum.
REQ-028 The 2-flop synchronizer with edge detection is one sub-module, sync_edge, instantiated three times.

Verification
REQ-029 Read of 0x0F (frame 16'h8F00) -> MISO bits on rises 9..16 = 8'h6A; INT stays 0.
REQ-030 Write 0x0D=8'h02, then yaw_rate=16'h1234, wait INT_PERIOD -> INT=1; read 0x26 gives 8'h34, read 0x27 gives 8'h12; INT=0 one clk after SS_n rise.
REQ-031 Write frame aborted after 12 bits -> no wr_strb; CTRL unchanged.
REQ-032 Write 0x10=8'hC3, read back -> 8'hC3; read of 0x55 -> 8'h00.
REQ-033 yaw_rate changed and timer wrap forced during a read of 0x27 -> returned byte from the old sample; new sample visible on the next read.
REQ-034 rst asserted mid-read -> MISO=0, INT=0, CTRL=0 next cycle; the following full frame completes normally.
